collision_scorer: RTL and testbench

//  Referee for the bird column. Once per game tick it compares the bird's one-hot

---
 rtl/collision_scorer.sv | 119 +++++++++++
 tb/tb_collision_scorer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scorer.sv
// Referee for the bird column: detects crashes and lost birds, counts cleared pipes
// in BCD, and keeps the best score until reset.
module collision_scorer #(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned MAX_SCORE = 99
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            enable,
    input  logic [ROWS-1:0] bird,
    input  logic [ROWS-1:0] pipe,
    input  logic            pipe_valid,
    output logic            gameOver,
    output logic            playing,
    output logic [3:0]      score_ones,
    output logic [3:0]      score_tens,
    output logic [3:0]      best_ones,
    output logic [3:0]      best_tens
);

    localparam logic [3:0] MaxTens = 4'(MAX_SCORE / 10);
    localparam logic [3:0] MaxOnes = 4'(MAX_SCORE % 10);

    typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

    state_e     state_q, state_d;
    logic       pv_q, pv_d;
    logic       game_over_q, game_over_d;
    logic       playing_q, playing_d;
    logic [3:0] score_ones_q, score_ones_d;
    logic [3:0] score_tens_q, score_tens_d;
    logic [3:0] best_ones_q, best_ones_d;
    logic [3:0] best_tens_q, best_tens_d;

    logic crash, one_hot, lost, pass, at_max, score_gt_best;

    assign crash   = pipe_valid & (|(bird & pipe));
    // x & (x-1) clears the lowest set bit, so zero here means at most one bit set.
    assign one_hot = (bird != '0) && ((bird & (bird - ROWS'(1))) == '0);
    assign lost    = ~one_hot;
    assign pass    = pv_q & ~pipe_valid;
    assign at_max  = (score_tens_q == MaxTens) && (score_ones_q == MaxOnes);
    assign score_gt_best = (score_tens_q > best_tens_q) ||
                           ((score_tens_q == best_tens_q) && (score_ones_q > best_ones_q));

    always_comb begin
        state_d      = state_q;
        pv_d         = pv_q;
        score_ones_d = score_ones_q;
        score_tens_d = score_tens_q;
        best_ones_d  = best_ones_q;
        best_tens_d  = best_tens_q;

        unique case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    state_d      = StPlay;
                    pv_d         = 1'b0;
                    score_ones_d = 4'd0;
                    score_tens_d = 4'd0;
                end
            end
            StPlay: begin
                if (enable) begin
                    pv_d = pipe_valid;
                    if (crash || lost) begin
                        state_d = StOver;
                        if (score_gt_best) begin
                            best_ones_d = score_ones_q;
                            best_tens_d = score_tens_q;
                        end
                    end else if (pass && !at_max) begin
                        if (score_ones_q == 4'd9) begin
                            score_ones_d = 4'd0;
                            score_tens_d = score_tens_q + 4'd1;
                        end else begin
                            score_ones_d = score_ones_q + 4'd1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        game_over_d = (state_d == StOver);
        playing_d   = (state_d == StPlay);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pv_q         <= 1'b0;
            game_over_q  <= 1'b0;
            playing_q    <= 1'b0;
            score_ones_q <= 4'd0;
            score_tens_q <= 4'd0;
            best_ones_q  <= 4'd0;
            best_tens_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            pv_q         <= pv_d;
            game_over_q  <= game_over_d;
            playing_q    <= playing_d;
            score_ones_q <= score_ones_d;
            score_tens_q <= score_tens_d;
            best_ones_q  <= best_ones_d;
            best_tens_q  <= best_tens_d;
        end
    end

    assign gameOver   = game_over_q;
    assign playing    = playing_q;
    assign score_ones = score_ones_q;
    assign score_tens = score_tens_q;
    assign best_ones  = best_ones_q;
    assign best_tens  = best_tens_q;

endmodule

// File: tb/tb_collision_scorer.sv
// Bench for collision_scorer: integer-score reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_collision_scorer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       enable;
    logic [7:0] bird;
    logic [7:0] pipe;
    logic       pipe_valid;
    logic       gameOver;
    logic       playing;
    logic [3:0] score_ones, score_tens, best_ones, best_tens;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 play, 2 over; score kept as a plain integer.
    int m_state;
    int m_score;
    int m_best;
    bit m_pv;

    collision_scorer #(.ROWS(8), .MAX_SCORE(99)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .enable     (enable),
        .bird       (bird),
        .pipe       (pipe),
        .pipe_valid (pipe_valid),
        .gameOver   (gameOver),
        .playing    (playing),
        .score_ones (score_ones),
        .score_tens (score_tens),
        .best_ones  (best_ones),
        .best_tens  (best_tens)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_score = 0;
        m_best  = 0;
        m_pv    = 1'b0;
    endtask

    task automatic model_step();
        bit crash, lost, pass;
        if (reset) return;
        if (m_state == 1) begin
            if (enable) begin
                crash = pipe_valid && ((bird & pipe) != 8'd0);
                lost  = ($countones(bird) != 1);
                pass  = m_pv && !pipe_valid;
                m_pv  = pipe_valid;
                if (crash || lost) begin
                    m_state = 2;
                    if (m_score > m_best) m_best = m_score;
                end else if (pass && m_score < 99) begin
                    m_score = m_score + 1;
                end
            end
        end else if (start) begin
            m_state = 1;
            m_score = 0;
            m_pv    = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        chk("gameOver", int'(gameOver), int'(m_state == 2));
        chk("playing", int'(playing), int'(m_state == 1));
        chk("score_ones", int'(score_ones), m_score % 10);
        chk("score_tens", int'(score_tens), m_score / 10);
        chk("best_ones", int'(best_ones), m_best % 10);
        chk("best_tens", int'(best_tens), m_best / 10);
    end

    task automatic tick(input bit st, input bit en, input logic [7:0] b,
                        input logic [7:0] p, input bit v);
        @(negedge clk);
        start      = st;
        enable     = en;
        bird       = b;
        pipe       = p;
        pipe_valid = v;
        @(posedge clk);
        model_step();
    endtask

    // One cleared pipe: overlap tick then leave tick.
    task automatic do_pass();
        tick(1'b0, 1'b1, 8'b0000_1000, 8'b1100_0011, 1'b1);
        tick(1'b0, 1'b1, 8'b0000_1000, 8'b0000_0000, 1'b0);
    endtask

    task automatic crash_tick();
        tick(1'b0, 1'b1, 8'b0001_0000, 8'b1111_0000, 1'b1);
    endtask

    task automatic mid_cycle_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_gameOver", int'(gameOver), 0);
        chk("async_playing", int'(playing), 0);
        chk("async_score", int'({score_tens, score_ones}), 0);
        chk("async_best", int'({best_tens, best_ones}), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        enable = 1'b0;
        bird = 8'd0;
        pipe = 8'd0;
        pipe_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", int'({gameOver, playing, score_tens, score_ones,
                                    best_tens, best_ones}), 0);
        @(negedge clk);
        reset = 1'b0;

        // Start from IDLE
        tick(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        #1;
        chk("start_playing", int'(playing), 1);
        chk("start_gameOver", int'(gameOver), 0);
        chk("start_score", int'({score_tens, score_ones}), 8'h00);

        // Pipe overlap for 3 ticks, then leaves: one point
        repeat (3) tick(1'b0, 1'b1, 8'b0000_1000, 8'b1100_0011, 1'b1);
        tick(1'b0, 1'b1, 8'b0000_1000, 8'b1100_0011, 1'b0);
        #1;
        chk("pass_score", int'({score_tens, score_ones}), 8'h01);
        chk("pass_no_over", int'(gameOver), 0);

        // Crash, then OVER holds through ticks
        crash_tick();
        #1;
        chk("crash_gameOver", int'(gameOver), 1);
        chk("crash_best", int'({best_tens, best_ones}), 8'h01);
        repeat (5) do_pass();
        #1;
        chk("over_hold_score", int'({score_tens, score_ones}), 8'h01);
        chk("over_hold_gameOver", int'(gameOver), 1);

        // BCD carry and saturation
        tick(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (9) do_pass();
        #1;
        chk("score_09", int'({score_tens, score_ones}), 8'h09);
        do_pass();
        #1;
        chk("score_10", int'({score_tens, score_ones}), 8'h10);
        repeat (89) do_pass();
        #1;
        chk("score_99", int'({score_tens, score_ones}), 8'h99);
        do_pass();
        #1;
        chk("score_sat", int'({score_tens, score_ones}), 8'h99);

        // Lost bird: none lit, then two lit
        tick(1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
        #1;
        chk("lost_zero", int'(gameOver), 1);
        chk("best_99", int'({best_tens, best_ones}), 8'h99);
        tick(1'b1, 1'b1, 8'd0, 8'd0, 1'b0);
        #1;
        chk("start_en_not_eval", int'(playing), 1);
        tick(1'b0, 1'b1, 8'b0000_0110, 8'd0, 1'b0);
        #1;
        chk("lost_two_hot", int'(gameOver), 1);

        // Best across games
        mid_cycle_reset();
        tick(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (5) do_pass();
        crash_tick();
        tick(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (3) do_pass();
        tick(1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
        #1;
        chk("best_05", int'({best_tens, best_ones}), 8'h05);
        chk("score_03", int'({score_tens, score_ones}), 8'h03);

        // Reset mid game 3, then start with no enable
        tick(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (2) do_pass();
        mid_cycle_reset();
        tick(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        tick(1'b0, 1'b0, 8'b0000_1000, 8'd0, 1'b1);
        tick(1'b0, 1'b0, 8'b0000_1000, 8'd0, 1'b0);
        tick(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        #1;
        chk("no_enable_score", int'({score_tens, score_ones}), 8'h00);
        chk("no_enable_playing", int'(playing), 1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
